// File: rtl/stop_watch_pkg.sv
// Shared types, 7-segment encodings, drive polarities and helpers for the N-digit stopwatch.
package stop_watch_pkg;
    typedef logic [3:0] bcd_t;

    localparam logic AN_ON  = 1'b0;
    localparam logic AN_OFF = 1'b1;
    localparam logic SEG_ON = 1'b0;

    localparam logic [6:0] SEG_DASH  = 7'b100_0000;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Lit-segment pattern {g,f,e,d,c,b,a}, 1 = segment on
    function automatic logic [6:0] seg_encode(input bcd_t digit);
        logic [6:0] lit;
        case (digit)
            4'd0:    lit = 7'h3F;
            4'd1:    lit = 7'h06;
            4'd2:    lit = 7'h5B;
            4'd3:    lit = 7'h4F;
            4'd4:    lit = 7'h66;
            4'd5:    lit = 7'h6D;
            4'd6:    lit = 7'h7D;
            4'd7:    lit = 7'h07;
            4'd8:    lit = 7'h7F;
            4'd9:    lit = 7'h6F;
            default: lit = SEG_BLANK;
        endcase
        return lit;
    endfunction

    function automatic logic [7:0] seg_drive(input logic [7:0] lit);
        return (SEG_ON == 1'b1) ? lit : ~lit;
    endfunction

    function automatic bcd_t bcd_clean(input logic [3:0] nib);
        return (nib > 4'd9) ? 4'd0 : nib;
    endfunction

    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width = width + 1;
        return width;
    endfunction

    function automatic int msb_index(input logic [7:0] mask);
        int top;
        top = -1;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) top = i;
        end
        return top;
    endfunction
endpackage

// File: rtl/scan_led_disp_n.sv
// NDIG-digit multiplexed 7-segment scanner with decimal points, leading-zero blanking and minus sign.
module scan_led_disp_n
    import stop_watch_pkg::*;
#(
    parameter int              CLK_HZ  = 50_000_000,
    parameter int              SCAN_HZ = 1000,
    parameter int              NDIG    = 4,
    parameter logic [NDIG-1:0] DP_MASK = 4'b0101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] digits,
    input  logic              minus,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        sseg
);
    localparam int SCAN_DIV = (CLK_HZ / (SCAN_HZ * NDIG) > 1) ? CLK_HZ / (SCAN_HZ * NDIG) : 1;
    localparam int SW       = clog2(SCAN_DIV);
    localparam int IW       = clog2(NDIG);
    localparam int DP_TOP   = msb_index(8'(DP_MASK));
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

    logic [SW-1:0]   scan_cnt_r;
    logic            scan_en_s;
    logic [IW-1:0]   idx_r, idx_nxt_s;
    logic [NDIG-1:0] blank_s, an_nxt_s, an_r;
    logic [7:0]      sseg_nxt_s, sseg_r;
    logic [6:0]      lit_s;
    bcd_t            cur_digit_s;

    assign scan_en_s = (scan_cnt_r == SCAN_LAST);

    // Scan-rate divider
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt_r <= '0;
        end else if (scan_en_s) begin
            scan_cnt_r <= '0;
        end else begin
            scan_cnt_r <= scan_cnt_r + SW'(1);
        end
    end

    // Leading-zero mask, walked from the most significant digit down; DP digits and digit 0 always show
    always_comb begin : blank_b
        logic zero_above_v;
        zero_above_v = 1'b1;
        blank_s      = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_above_v = zero_above_v & (digits[4*i +: 4] == 4'd0);
            blank_s[i]   = zero_above_v && (i > DP_TOP) && (i > 0);
        end
    end

    // Segment, anode and next-index values for the digit currently selected
    always_comb begin
        cur_digit_s = digits[{idx_r, 2'b00} +: 4];
        if (blank_s[idx_r]) begin
            lit_s = (minus && (idx_r == IDX_LAST)) ? SEG_DASH : SEG_BLANK;
        end else begin
            lit_s = seg_encode(cur_digit_s);
        end
        sseg_nxt_s = seg_drive({DP_MASK[idx_r], lit_s});
        for (int i = 0; i < NDIG; i++) begin
            an_nxt_s[i] = (idx_r == IW'(i)) ? AN_ON : AN_OFF;
        end
        idx_nxt_s = (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
    end

    // Registered display outputs, refreshed once per scan step
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_r  <= '0;
            an_r   <= {NDIG{AN_OFF}};
            sseg_r <= seg_drive(8'h00);
        end else if (scan_en_s) begin
            idx_r  <= idx_nxt_s;
            an_r   <= an_nxt_s;
            sseg_r <= sseg_nxt_s;
        end else begin
            idx_r  <= idx_r;
            an_r   <= an_r;
            sseg_r <= sseg_r;
        end
    end

    assign an   = an_r;
    assign sseg = sseg_r;
endmodule

// File: rtl/stop_watch_ndigit.sv
// N-digit BCD sign-magnitude up/down stopwatch on a single clock with tick enables and 7-seg scan.
// Optional lap-freeze of the display is built when STOP_WATCH_LAP_EN is defined.
module stop_watch_ndigit
    import stop_watch_pkg::*;
#(
    parameter int              CLK_HZ  = 50_000_000,
    parameter int              TICK_HZ = 100,
    parameter int              SCAN_HZ = 1000,
    parameter int              NDIG    = 4,
    parameter logic [NDIG-1:0] DP_MASK = 4'b0101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set,
    input  logic              pause,
    input  logic              up,
    input  logic [4*NDIG-1:0] preset,
`ifdef STOP_WATCH_LAP_EN
    input  logic              lap,
`endif
    output logic [NDIG-1:0]   an,
    output logic [7:0]        sseg,
    output logic              minus_flag,
    output logic              ovf
);
    localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 1;
    localparam int TW       = clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]     tick_cnt_r;
    logic              tick_s;
    logic [4*NDIG-1:0] mag_r, mag_nxt_s, inc_s, dec_s, preset_clean_s, disp_mag_s;
    logic              minus_r, minus_nxt_s, ovf_r, ovf_nxt_s;
    logic              all_nine_s, is_zero_s, disp_minus_s;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Count-rate divider; free-running so pause/up changes land on the next natural tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // BCD +1 / -1 with full ripple; the final carry/borrow flag all-nines / zero magnitude
    always_comb begin : bcd_step_b
        logic carry_v, borrow_v;
        carry_v        = 1'b1;
        borrow_v       = 1'b1;
        inc_s          = '0;
        dec_s          = '0;
        preset_clean_s = '0;
        for (int i = 0; i < NDIG; i++) begin
            inc_s[4*i +: 4] = carry_v ? ((mag_r[4*i +: 4] == 4'd9) ? 4'd0 : mag_r[4*i +: 4] + 4'd1)
                                      : mag_r[4*i +: 4];
            dec_s[4*i +: 4] = borrow_v ? ((mag_r[4*i +: 4] == 4'd0) ? 4'd9 : mag_r[4*i +: 4] - 4'd1)
                                       : mag_r[4*i +: 4];
            carry_v  = carry_v & (mag_r[4*i +: 4] == 4'd9);
            borrow_v = borrow_v & (mag_r[4*i +: 4] == 4'd0);
            preset_clean_s[4*i +: 4] = bcd_clean(preset[4*i +: 4]);
        end
        all_nine_s = carry_v;
        is_zero_s  = borrow_v;
    end

    // Sign-magnitude next state: moving away from zero grows the magnitude, toward zero shrinks it
    always_comb begin
        mag_nxt_s   = mag_r;
        minus_nxt_s = minus_r;
        ovf_nxt_s   = ovf_r;
        if (set) begin
            mag_nxt_s   = preset_clean_s;
            minus_nxt_s = 1'b0;
            ovf_nxt_s   = 1'b0;
        end else if (tick_s && !pause) begin
            if (up != minus_r) begin
                if (all_nine_s) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    mag_nxt_s = inc_s;
                end
            end else if (is_zero_s) begin
                mag_nxt_s   = (4*NDIG)'(1);
                minus_nxt_s = 1'b1;
            end else begin
                mag_nxt_s   = dec_s;
                minus_nxt_s = minus_r & (dec_s != '0);
            end
        end else begin
            mag_nxt_s = mag_r;
        end
    end

    // Counter state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            mag_r   <= '0;
            minus_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            mag_r   <= mag_nxt_s;
            minus_r <= minus_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

`ifdef STOP_WATCH_LAP_EN
    logic              frz_r, snap_minus_r;
    logic [4*NDIG-1:0] snap_mag_r;

    // Lap freeze toggles on each pulse and captures the live value; set releases it
    always_ff @(posedge clk) begin
        if (!reset) begin
            frz_r        <= 1'b0;
            snap_mag_r   <= '0;
            snap_minus_r <= 1'b0;
        end else if (set) begin
            frz_r        <= 1'b0;
            snap_mag_r   <= snap_mag_r;
            snap_minus_r <= snap_minus_r;
        end else if (lap) begin
            frz_r        <= ~frz_r;
            snap_mag_r   <= mag_r;
            snap_minus_r <= minus_r;
        end else begin
            frz_r        <= frz_r;
            snap_mag_r   <= snap_mag_r;
            snap_minus_r <= snap_minus_r;
        end
    end

    assign disp_mag_s   = frz_r ? snap_mag_r : mag_r;
    assign disp_minus_s = frz_r ? snap_minus_r : minus_r;
`else
    assign disp_mag_s   = mag_r;
    assign disp_minus_s = minus_r;
`endif

    scan_led_disp_n #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .NDIG    (NDIG),
        .DP_MASK (DP_MASK)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .digits (disp_mag_s),
        .minus  (disp_minus_s),
        .an     (an),
        .sseg   (sseg)
    );

    assign minus_flag = minus_r;
    assign ovf        = ovf_r;
endmodule

// File: tb/tb_stop_watch_ndigit.sv
// Self-checking bench for stop_watch_ndigit: directed scenarios plus randomized runs against a signed-integer model.
module tb_stop_watch_ndigit;
    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 100;
    localparam int SCAN_HZ  = 25;
    localparam int NDIG     = 4;
    localparam logic [3:0] DP = 4'b0101;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int MAXV     = 9999;
    localparam logic [6:0] LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        reset, set, pause, up;
    logic [15:0] preset;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        minus_flag, ovf;
`ifdef STOP_WATCH_LAP_EN
    logic        lap;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    int m_div    = 0;
    int m_val    = 0;
    bit m_ovf    = 1'b0;

    stop_watch_ndigit #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .NDIG    (NDIG),
        .DP_MASK (DP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .set        (set),
        .pause      (pause),
        .up         (up),
        .preset     (preset),
`ifdef STOP_WATCH_LAP_EN
        .lap        (lap),
`endif
        .an         (an),
        .sseg       (sseg),
        .minus_flag (minus_flag),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int preset_val(input logic [15:0] p);
        int v, w;
        logic [3:0] nib;
        v = 0;
        w = 1;
        for (int i = 0; i < NDIG; i++) begin
            nib = p[4*i +: 4];
            if (nib <= 4'd9) v += int'(nib) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic bit out_of_range(input int v);
        return (v > MAXV) || (v < -MAXV);
    endfunction

    function automatic int dp_top();
        int top;
        top = -1;
        for (int i = 0; i < NDIG; i++) if (DP[i]) top = i;
        return top;
    endfunction

    // Expected active-low segment byte for digit i of signed value v
    function automatic logic [7:0] exp_sseg(input int v, input int i);
        int mag, pw, d;
        bit blank;
        logic [6:0] lit;
        mag = (v < 0) ? -v : v;
        pw  = 1;
        for (int k = 0; k < i; k++) pw *= 10;
        d     = (mag / pw) % 10;
        blank = (i > 0) && (i > dp_top()) && (mag < pw);
        lit   = blank ? (((v < 0) && (i == NDIG - 1)) ? 7'h40 : 7'h00) : LUT[d];
        return ~{DP[i], lit};
    endfunction

    // Reference model: signed count, +/-1 per unpaused tick, held with sticky ovf beyond +/-MAXV
    always @(posedge clk) begin
        if (!reset) begin
            m_div <= 0;
            m_val <= 0;
            m_ovf <= 1'b0;
        end else begin
            m_div <= (m_div == TICK_DIV - 1) ? 0 : m_div + 1;
            if (set) begin
                m_val <= preset_val(preset);
                m_ovf <= 1'b0;
            end else if ((m_div == TICK_DIV - 1) && !pause) begin
                if (out_of_range(up ? m_val + 1 : m_val - 1)) m_ovf <= 1'b1;
                else m_val <= up ? m_val + 1 : m_val - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("mon_minus", 32'(minus_flag), 32'(m_val < 0));
            check_eq("mon_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic check_display(input string tag, input int v);
        logic [7:0] got [NDIG];
        bit seen [NDIG];
        int bad;
        bit hit, save_p;
        save_p = pause;
        pause  = 1'b1;
        bad    = 0;
        for (int i = 0; i < NDIG; i++) begin
            got[i]  = 8'h00;
            seen[i] = 1'b0;
        end
        repeat (45) @(negedge clk);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            hit = 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                if (an == ~(4'b0001 << i)) begin
                    got[i]  = sseg;
                    seen[i] = 1'b1;
                    hit     = 1'b1;
                end
            end
            if (!hit) bad++;
        end
        check_eq({tag, "_an"}, 32'(bad), 32'd0);
        for (int i = 0; i < NDIG; i++) begin
            check_eq($sformatf("%s_seen%0d", tag, i), 32'(seen[i]), 32'd1);
            check_eq($sformatf("%s_dig%0d", tag, i), 32'(got[i]), 32'(exp_sseg(v, i)));
        end
        pause = save_p;
    endtask

    task automatic check_state(input string tag, input int v, input bit o, input int d);
        check_eq({tag, "_minus"}, 32'(minus_flag), 32'(v < 0));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(o));
        check_display(tag, d);
    endtask

    task automatic load(input logic [15:0] p);
        preset = p;
        set    = 1'b1;
        @(negedge clk);
        set = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            for (int k = 0; (k < 2 * TICK_DIV) && (m_div != TICK_DIV - 1); k++) @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_an"}, 32'(an), 32'hF);
        check_eq({tag, "_sseg"}, 32'(sseg), 32'hFF);
        check_eq({tag, "_minus"}, 32'(minus_flag), 32'd0);
        check_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        set    = 1'b0;
        pause  = 1'b0;
        up     = 1'b1;
        preset = 16'h0000;
`ifdef STOP_WATCH_LAP_EN
        lap    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset("rst");
        mon_en = 1'b1;
        reset  = 1'b1;

        wait_ticks(12);
        check_state("t1_0012", 12, 1'b0, 12);

        load(16'h0199);
        wait_ticks(1);
        check_state("t2_0200", 200, 1'b0, 200);
        up = 1'b0;
        wait_ticks(1);
        check_state("t2_0199", 199, 1'b0, 199);

        load(16'h0001);
        wait_ticks(1);
        check_state("t3_0000", 0, 1'b0, 0);
        wait_ticks(1);
        check_state("t3_m0001", -1, 1'b0, -1);
        wait_ticks(1);
        check_state("t3_m0002", -2, 1'b0, -2);
        up = 1'b1;
        wait_ticks(2);
        check_state("t3_back0", 0, 1'b0, 0);

        load(16'h9998);
        wait_ticks(1);
        check_state("t4_9999", 9999, 1'b0, 9999);
        wait_ticks(1);
        check_state("t4_sat", 9999, 1'b1, 9999);
        wait_ticks(1);
        check_state("t4_sticky", 9999, 1'b1, 9999);
        load(16'h0000);
        check_state("t4_clr", 0, 1'b0, 0);

        load(16'h0042);
        pause = 1'b1;
        repeat (50) @(negedge clk);
        check_state("t5_pause", 42, 1'b0, 42);
        pause = 1'b0;
        for (int k = 0; (k < 2 * TICK_DIV) && (m_div != TICK_DIV - 1); k++) @(negedge clk);
        load(16'h0300);
        check_state("t5_setwin", 300, 1'b0, 300);
        load(16'h0005);
        up = 1'b0;
        wait_ticks(8);
        check_state("t5_m0003", -3, 1'b0, -3);
        repeat ($urandom_range(1, 9)) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("t5_rst");
        reset = 1'b1;
        up    = 1'b1;
        check_state("t5_after", 0, 1'b0, 0);

        load(16'h0007);
        check_state("t6_0007", 7, 1'b0, 7);
        load(16'h0000);
        up = 1'b0;
        wait_ticks(7);
        check_state("t6_m0007", -7, 1'b0, -7);

`ifdef STOP_WATCH_LAP_EN
        up = 1'b1;
        load(16'h0100);
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        wait_ticks(5);
        check_state("lap_frz", m_val, m_ovf, 100);
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        check_state("lap_rel", m_val, m_ovf, m_val);
`endif

        for (int it = 0; it < 25; it++) begin
            int r;
            r  = $urandom_range(0, 5);
            up = 1'($urandom_range(0, 1));
            if (r == 0) load(16'($urandom));
            else if (r == 1) load(16'h9990 | 16'($urandom_range(5, 9)));
            else if (r == 2) load(16'($urandom_range(0, 2)));
            pause = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(5, 150)) @(negedge clk);
            check_state($sformatf("rnd%0d", it), m_val, m_ovf, m_val);
            pause = 1'b0;
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
